// File: rtl/multi_frame_buffer_if.sv
// multi_frame_buffer_if: draw/read/control bundle between renderer, display and frame store
interface multi_frame_buffer_if #(parameter int BPP = 1);
  logic           frame_clk_rising_edge;
  logic           frame_done;
  logic           draw_we;
  logic [9:0]     DrawX;
  logic [9:0]     DrawY;
  logic [BPP-1:0] draw_data;
  logic [9:0]     ReadX;
  logic [9:0]     ReadY;
  logic [BPP-1:0] read_data;
  logic           draw_ready;
  logic [1:0]     front_idx;
  logic [1:0]     draw_idx;
  logic [15:0]    frame_count;
  logic [7:0]     drop_count;
  modport master (
    output frame_clk_rising_edge, frame_done, draw_we, DrawX, DrawY, draw_data, ReadX, ReadY,
    input  read_data, draw_ready, front_idx, draw_idx, frame_count, drop_count
  );
  modport slave (
    input  frame_clk_rising_edge, frame_done, draw_we, DrawX, DrawY, draw_data, ReadX, ReadY,
    output read_data, draw_ready, front_idx, draw_idx, frame_count, drop_count
  );
endinterface

// File: rtl/multi_frame_buffer.sv
// multi_frame_buffer: double/triple-buffered frame store with vsync-synchronised rotation
module multi_frame_buffer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int BPP     = 1,
  parameter int NUM_BUF = 2
) (
  input logic Clk,
  input logic Reset_n,
  multi_frame_buffer_if.slave bus
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = $clog2(NUM_BUF * DEPTH);
  typedef enum logic {DRAWING, WAIT_SWAP} state_t;
  generate
    if (NUM_BUF != 2 && NUM_BUF != 3) begin : g_bad_num_buf
      $error("multi_frame_buffer: NUM_BUF must be 2 or 3");
    end
  endgenerate
  state_t         state, state_n;
  logic [1:0]     front, draw, ready, front_n, draw_n, ready_n, free;
  logic           ready_v, ready_v_n, drop_inc, draw_ok, wr_ok, rd_ok;
  logic [15:0]    frames, frames_n;
  logic [7:0]     drops, drops_n;
  logic [AW-1:0]  waddr, raddr;
  logic [BPP-1:0] mem [NUM_BUF*DEPTH];
  logic [BPP-1:0] rdata;
  // with three buffers the indices sum to 3, so the unused one is the remainder
  assign free    = 2'd3 - front - draw;
  assign draw_ok = NUM_BUF == 3 || state == DRAWING;
  assign wr_ok   = bus.draw_we && draw_ok && bus.DrawX < 10'(H_RES) && bus.DrawY < 10'(V_RES);
  assign rd_ok   = bus.ReadX < 10'(H_RES) && bus.ReadY < 10'(V_RES);
  assign waddr   = AW'(draw) * AW'(DEPTH) + AW'(bus.DrawY) * AW'(H_RES) + AW'(bus.DrawX);
  assign raddr   = AW'(front) * AW'(DEPTH) + AW'(bus.ReadY) * AW'(H_RES) + AW'(bus.ReadX);
  // role rotation: a finished frame on a vsync tick goes straight to the display
  always_comb begin
    state_n   = state;
    front_n   = front;
    draw_n    = draw;
    ready_n   = ready;
    ready_v_n = ready_v;
    frames_n  = frames;
    drop_inc  = 1'b0;
    if (NUM_BUF == 2) begin
      if (bus.frame_clk_rising_edge && (state == WAIT_SWAP || bus.frame_done)) begin
        front_n  = draw;
        draw_n   = front;
        frames_n = frames + 16'd1;
        state_n  = DRAWING;
      end else if (bus.frame_done && state == DRAWING) begin
        state_n = WAIT_SWAP;
      end
    end else begin
      if (bus.frame_done && bus.frame_clk_rising_edge) begin
        front_n   = draw;
        draw_n    = front;
        ready_v_n = 1'b0;
        drop_inc  = ready_v;
        frames_n  = frames + 16'd1;
      end else if (bus.frame_done) begin
        ready_n   = draw;
        draw_n    = ready_v ? ready : free;
        ready_v_n = 1'b1;
        drop_inc  = ready_v;
      end else if (bus.frame_clk_rising_edge && ready_v) begin
        front_n   = ready;
        ready_v_n = 1'b0;
        frames_n  = frames + 16'd1;
      end
    end
    drops_n = (drop_inc && drops != 8'hFF) ? drops + 8'd1 : drops;
  end
  // role and counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= DRAWING;
      front   <= 2'd0;
      draw    <= 2'd1;
      ready   <= 2'd0;
      ready_v <= 1'b0;
      frames  <= 16'd0;
      drops   <= 8'd0;
    end else begin
      state   <= state_n;
      front   <= front_n;
      draw    <= draw_n;
      ready   <= ready_n;
      ready_v <= ready_v_n;
      frames  <= frames_n;
      drops   <= drops_n;
    end
  end
  // pixel store; contents survive reset
  always_ff @(posedge Clk) begin
    if (wr_ok) mem[waddr] <= bus.draw_data;
  end
  // registered front-buffer read, zero outside the visible area
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rdata <= '0;
    else rdata <= rd_ok ? mem[raddr] : '0;
  end
  assign bus.read_data   = rdata;
  assign bus.draw_ready  = draw_ok;
  assign bus.front_idx   = front;
  assign bus.draw_idx    = draw;
  assign bus.frame_count = frames;
  assign bus.drop_count  = drops;
endmodule

// File: tb/tb_multi_frame_buffer.sv
// tb_multi_frame_buffer: directed checks of double (1 bpp) and triple (4 bpp) frame buffers
module tb_multi_frame_buffer;
  logic Clk;
  logic Reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  multi_frame_buffer_if #(.BPP(1)) if2 ();
  multi_frame_buffer_if #(.BPP(4)) if3 ();
  multi_frame_buffer #(.H_RES(640), .V_RES(480), .BPP(1), .NUM_BUF(2)) u2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if2)
  );
  multi_frame_buffer #(.H_RES(640), .V_RES(480), .BPP(4), .NUM_BUF(3)) u3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if3)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic wr2(input logic [9:0] x, input logic [9:0] y, input logic d);
    if2.DrawX = x; if2.DrawY = y; if2.draw_data = d; if2.draw_we = 1'b1;
    tick();
    if2.draw_we = 1'b0;
  endtask
  task automatic rd2(input logic [9:0] x, input logic [9:0] y);
    if2.ReadX = x; if2.ReadY = y;
    tick();
  endtask
  task automatic wr3(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
    if3.DrawX = x; if3.DrawY = y; if3.draw_data = d; if3.draw_we = 1'b1;
    tick();
    if3.draw_we = 1'b0;
  endtask
  task automatic rd3(input logic [9:0] x, input logic [9:0] y);
    if3.ReadX = x; if3.ReadY = y;
    tick();
  endtask
  initial begin
    Reset_n = 1'b0;
    if2.frame_clk_rising_edge = 0; if2.frame_done = 0; if2.draw_we = 0;
    if2.DrawX = 0; if2.DrawY = 0; if2.draw_data = 0; if2.ReadX = 0; if2.ReadY = 0;
    if3.frame_clk_rising_edge = 0; if3.frame_done = 0; if3.draw_we = 0;
    if3.DrawX = 0; if3.DrawY = 0; if3.draw_data = 0; if3.ReadX = 0; if3.ReadY = 0;
    #12;
    chk("t1_front", 32'(if2.front_idx), 0);
    chk("t1_draw", 32'(if2.draw_idx), 1);
    chk("t1_ready", 32'(if2.draw_ready), 1);
    chk("t1_rdata", 32'(if2.read_data), 0);
    chk("t1_frames", 32'(if2.frame_count), 0);
    chk("t1_drops", 32'(if3.drop_count), 0);
    chk("t1_ready3", 32'(if3.draw_ready), 1);
    chk("t1_rdata3", 32'(if3.read_data), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    tick();
    wr2(0, 0, 0);
    wr2(6, 7, 0);
    wr2(5, 7, 1);
    if2.frame_done = 1; tick(); if2.frame_done = 0;
    chk("t2_ready_low", 32'(if2.draw_ready), 0);
    wr2(6, 7, 1);
    chk("t2_draw_hold", 32'(if2.draw_idx), 1);
    chk("t2_front_hold", 32'(if2.front_idx), 0);
    if2.frame_clk_rising_edge = 1; tick(); if2.frame_clk_rising_edge = 0;
    chk("t2_front", 32'(if2.front_idx), 1);
    chk("t2_draw", 32'(if2.draw_idx), 0);
    chk("t2_frames", 32'(if2.frame_count), 1);
    chk("t2_ready_high", 32'(if2.draw_ready), 1);
    rd2(5, 7);
    chk("t2_rd_5_7", 32'(if2.read_data), 1);
    rd2(6, 7);
    chk("t2_rd_6_7", 32'(if2.read_data), 0);
    wr2(0, 1, 0);
    wr2(60, 11, 1);
    wr2(5, 7, 1);
    wr2(640, 0, 1);
    wr2(0, 480, 1);
    rd2(0, 0);
    chk("t5_no_alias_front", 32'(if2.read_data), 0);
    if2.frame_done = 1; if2.frame_clk_rising_edge = 1; tick();
    if2.frame_done = 0; if2.frame_clk_rising_edge = 0;
    chk("t4_front", 32'(if2.front_idx), 0);
    chk("t4_draw", 32'(if2.draw_idx), 1);
    chk("t4_frames", 32'(if2.frame_count), 2);
    chk("t4_ready", 32'(if2.draw_ready), 1);
    rd2(0, 1);
    chk("t5_no_alias_x", 32'(if2.read_data), 0);
    rd2(60, 11);
    chk("t5_rd_60_11", 32'(if2.read_data), 1);
    rd2(700, 10);
    chk("t5_rd_oob", 32'(if2.read_data), 0);
    rd2(5, 7);
    chk("t4_rd_5_7", 32'(if2.read_data), 1);
    wr3(0, 0, 4'hA);
    if3.frame_done = 1; tick(); if3.frame_done = 0;
    chk("t3_draw_a", 32'(if3.draw_idx), 2);
    chk("t3_ready_a", 32'(if3.draw_ready), 1);
    chk("t3_drops_a", 32'(if3.drop_count), 0);
    wr3(0, 0, 4'hB);
    if3.frame_done = 1; tick(); if3.frame_done = 0;
    chk("t3_draw_b", 32'(if3.draw_idx), 1);
    chk("t3_ready_b", 32'(if3.draw_ready), 1);
    chk("t3_drops_b", 32'(if3.drop_count), 1);
    chk("t3_front_hold", 32'(if3.front_idx), 0);
    if3.frame_clk_rising_edge = 1; tick(); if3.frame_clk_rising_edge = 0;
    chk("t3_front", 32'(if3.front_idx), 2);
    chk("t3_frames", 32'(if3.frame_count), 1);
    rd3(0, 0);
    chk("t3_rd_b", 32'(if3.read_data), 32'hB);
    if3.frame_clk_rising_edge = 1; tick(); if3.frame_clk_rising_edge = 0;
    chk("t3_idle_tick_front", 32'(if3.front_idx), 2);
    chk("t3_idle_tick_frames", 32'(if3.frame_count), 1);
    if3.frame_done = 1; tick(); if3.frame_done = 0;
    chk("t4_3_draw_pre", 32'(if3.draw_idx), 0);
    if3.DrawX = 1; if3.DrawY = 1; if3.draw_data = 4'hC; if3.draw_we = 1;
    if3.frame_done = 1; if3.frame_clk_rising_edge = 1; tick();
    if3.draw_we = 0; if3.frame_done = 0; if3.frame_clk_rising_edge = 0;
    chk("t4_3_front", 32'(if3.front_idx), 0);
    chk("t4_3_draw", 32'(if3.draw_idx), 2);
    chk("t4_3_drops", 32'(if3.drop_count), 2);
    chk("t4_3_frames", 32'(if3.frame_count), 2);
    rd3(1, 1);
    chk("t4_3_late_write", 32'(if3.read_data), 32'hC);
    if2.frame_done = 1; if2.frame_clk_rising_edge = 1; if3.frame_done = 1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge Clk); #1;
      if (i == 299) if3.frame_done = 0;
    end
    if2.frame_done = 0; if2.frame_clk_rising_edge = 0;
    chk("t6_frame_wrap", 32'(if2.frame_count), 0);
    chk("t6_front_after_wrap", 32'(if2.front_idx), 0);
    chk("t6_drop_sat", 32'(if3.drop_count), 32'hFF);
    chk("t6_draw3", 32'(if3.draw_idx), 2);
    Reset_n = 1'b0;
    #1;
    chk("rst_async_draw3", 32'(if3.draw_idx), 1);
    chk("rst_async_drops", 32'(if3.drop_count), 0);
    chk("rst_async_frames3", 32'(if3.frame_count), 0);
    chk("rst_async_rdata3", 32'(if3.read_data), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
